bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_slot_counter.sv | 15 +
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and frame timing for the Pi/CPU RAM arbiter.
// Phase constants are offsets within an 8-cycle window; *_PRE values name the cycle before the output takes effect.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PI_ACCESS,
      PI_ACK,
      CPU_ACCESS
   } arb_state_t;

   localparam int          FRAME_LEN     = 16;
   localparam int          CNT_W         = 4;

   localparam logic [3:0]  PI_START      = 4'd0;
   localparam logic [3:0]  CPU_START     = 4'd8;
   localparam logic [3:0]  CPU_EN_PRE    = 4'd14;
   localparam logic [3:0]  FRAME_END     = 4'd15;

   localparam logic [2:0]  ADDR_LAST_PRE = 3'd5;
   localparam logic [2:0]  STB_FIRST_PRE = 3'd1;
   localparam logic [2:0]  STB_LAST_PRE  = 3'd4;
   localparam logic [2:0]  CAPTURE_PH    = 3'd5;
   localparam logic [2:0]  DONE_PH       = 3'd6;

   function automatic logic strobe_next(input logic [2:0] ph);
      return (ph >= STB_FIRST_PRE) && (ph <= STB_LAST_PRE);
   endfunction

endpackage

// File: rtl/bus_slot_counter.sv
// Free-running 4-bit slot counter that defines the 16-cycle arbitration frame.
module bus_slot_counter
   import bus_arbiter_pkg::*;
(
   input  logic             sys_clk,
   input  logic             reset_n,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge sys_clk) begin
      if (!reset_n) count <= '0;
      else          count <= count + 4'd1;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Time-sliced RAM arbiter: Pi bridge owns slots 0-7, CPU owns slots 8-15.
// Optional BUS_ARBITER_CPU_HALT_EN adds cpu_halt_in, which lends slots 8-15 to a second Pi access.
//
// state      | meaning
// IDLE       | no owner; waiting for a window start
// PI_ACCESS  | Pi access in progress (address/strobe/capture phases)
// PI_ACK     | Pi access finished; done handshake held in pi_done_out
// CPU_ACCESS | CPU access in progress, ends at slot 15
module bus_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic        pi_pending_in,
   input  logic        pi_rw_b_in,
   input  logic [16:0] pi_addr_in,
   input  logic [7:0]  pi_wr_data_in,
   output logic [7:0]  pi_rd_data_out,
   output logic        pi_done_out,
   input  logic [15:0] cpu_addr_in,
   input  logic        cpu_rw_b_in,
   input  logic [7:0]  cpu_wr_data_in,
`ifdef BUS_ARBITER_CPU_HALT_EN
   input  logic        cpu_halt_in,
`endif
   output logic [7:0]  cpu_rd_data_out,
   output logic        cpu_en_out,
   output logic [16:0] ram_addr_out,
   output logic [7:0]  ram_data_out,
   input  logic [7:0]  ram_data_in,
   output logic        ram_we_n_out,
   output logic        ram_oe_n_out
);

   logic [CNT_W-1:0] count;
   logic [2:0]       phase;
   arb_state_t       state;
   logic [16:0]      pi_addr_q;
   logic             pi_rw_q;
   logic [7:0]       pi_wd_q;
   logic             cpu_rw_q;
   logic [7:0]       cpu_wd_q;
   logic             halt_frame;
   logic             halt_req;
   logic             pi_accept;

   bus_slot_counter u_slot (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .count   (count)
   );

`ifdef BUS_ARBITER_CPU_HALT_EN
   assign halt_req = cpu_halt_in;
`else
   assign halt_req = 1'b0;
`endif

   assign phase = count[2:0];

   // A held request after done is ignored until the handshake completes.
   assign pi_accept = pi_pending_in && !pi_done_out &&
                      ((count == PI_START) || ((count == CPU_START) && halt_req));

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         pi_addr_q       <= '0;
         pi_rw_q         <= 1'b1;
         pi_wd_q         <= '0;
         cpu_rw_q        <= 1'b1;
         cpu_wd_q        <= '0;
         halt_frame      <= 1'b0;
         ram_we_n_out    <= 1'b1;
         ram_oe_n_out    <= 1'b1;
         ram_addr_out    <= '0;
         ram_data_out    <= '0;
         cpu_en_out      <= 1'b0;
         pi_done_out     <= 1'b0;
         pi_rd_data_out  <= '0;
         cpu_rd_data_out <= '0;
      end else begin
         ram_we_n_out <= 1'b1;
         ram_oe_n_out <= 1'b1;
         ram_addr_out <= '0;
         ram_data_out <= '0;
         cpu_en_out   <= (count == CPU_EN_PRE) && !halt_frame;

         if (pi_done_out && !pi_pending_in) pi_done_out <= 1'b0;
         if (count == CPU_START) halt_frame <= halt_req;

         case (state)
            IDLE, PI_ACK: begin
               if (pi_accept) begin
                  state        <= PI_ACCESS;
                  pi_addr_q    <= pi_addr_in;
                  pi_rw_q      <= pi_rw_b_in;
                  pi_wd_q      <= pi_wr_data_in;
                  ram_addr_out <= pi_addr_in;
                  ram_data_out <= pi_rw_b_in ? 8'h00 : pi_wr_data_in;
               end else if (count == CPU_START) begin
                  state <= halt_req ? IDLE : CPU_ACCESS;
                  if (!halt_req) begin
                     cpu_rw_q     <= cpu_rw_b_in;
                     cpu_wd_q     <= cpu_wr_data_in;
                     ram_addr_out <= {1'b0, cpu_addr_in};
                     ram_data_out <= cpu_rw_b_in ? 8'h00 : cpu_wr_data_in;
                  end
               end else if (count == FRAME_END) begin
                  state <= IDLE;
               end
            end

            PI_ACCESS: begin
               if (phase <= ADDR_LAST_PRE) begin
                  ram_addr_out <= pi_addr_q;
                  ram_data_out <= pi_rw_q ? 8'h00 : pi_wd_q;
               end
               if (strobe_next(phase)) begin
                  ram_we_n_out <= pi_rw_q;
                  ram_oe_n_out <= !pi_rw_q;
               end
               if ((phase == CAPTURE_PH) && pi_rw_q) pi_rd_data_out <= ram_data_in;
               if (phase == DONE_PH) begin
                  pi_done_out <= 1'b1;
                  state       <= PI_ACK;
               end
            end

            CPU_ACCESS: begin
               // CPU address is followed live; the CPU only moves it on cpu_en_out.
               if (phase <= ADDR_LAST_PRE) begin
                  ram_addr_out <= {1'b0, cpu_addr_in};
                  ram_data_out <= cpu_rw_q ? 8'h00 : cpu_wd_q;
               end
               if (strobe_next(phase)) begin
                  ram_we_n_out <= cpu_rw_q;
                  ram_oe_n_out <= !cpu_rw_q;
               end
               if ((phase == CAPTURE_PH) && cpu_rw_q) cpu_rd_data_out <= ram_data_in;
               if (count == FRAME_END) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
